vga_scan_driver: RTL and testbench
==================================

# vga_scan_driver

Raster scan generator and pixel output stage for the VGA display path. It produces the pixel coordinate pair (x, y) that the combinational shape hit-testers (parallelograms, rectangles) evaluate. It collects their hit result and emits registered RGB and sync signals to the DAC pins. It drives the coordinate interface from the producer side and consumes the hit flag that the painters return.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- FG_COLOR, 9'b111_111_111, RGB333 colour for hit pixels
- BG_COLOR, 9'b000_000_000, RGB333 colour for non-hit active pixels

Ports:
- clk  in  1  system clock; all logic on its rising edge
- rst  in  1  synchronous reset, active-low
- pix_en  in  1  pixel-rate strobe; counters and output stage advance only when high
- x  out  11  current horizontal count, 0..H_TOTAL-1
- y  out  11  current vertical count, 0..V_TOTAL-1
- hit  in  1  combinational hit flag from painters, a function of the current x and y
- hsync  out  1  horizontal sync, active-low, registered
- vsync  out  1  vertical sync, active-low, registered
- red, green, blue  out  3 each  registered pixel colour
- video_on  out  1  registered; high when the emitted pixel is in the active area
- frame_start  out  1  one-clk pulse marking the first pixel (0,0) of each frame

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). All comparisons are unsigned 11-bit.
- Stage 0 (counters) advances on clk only when pix_en=1:
  - x increments by 1.
  - When x = H_TOTAL-1, x wraps to 0 and y increments.
  - When x = H_TOTAL-1 and y = V_TOTAL-1, both x and y wrap to 0.
- Counters run through blanking. x and y present the raw counts, so painters see values ≥ H_ACTIVE / V_ACTIVE. Masking of those pixels is done here, not in the painters.
- Stage 1 (output register) loads on clk only when pix_en=1, from the stage-0 values:
  - active = (x < H_ACTIVE) && (y < V_ACTIVE).
  - video_on <= active.
  - rgb <= active ? (hit ? FG_COLOR : BG_COLOR) : 0.
  - hsync <= !(x ≥ H_ACTIVE+H_FP && x < H_ACTIVE+H_FP+H_SYNC), i.e. low for x in 656..751.
  - vsync <= !(y ≥ V_ACTIVE+V_FP && y < V_ACTIVE+V_FP+V_SYNC), i.e. low for y in 490..491.
- frame_start is asserted for exactly one clk, on the clk where stage 1 loads pixel (0,0) and pix_en=1. It is 0 on all other clks.
- When pix_en=0, everything holds its value and frame_start=0.

## Timing
- Reset (rst=0 at a clk edge) sets:
  - x=0, y=0
  - hsync=1, vsync=1
  - red/green/blue=0
  - video_on=0
  - frame_start=0
- Reset takes priority over pix_en.
- Reset applied mid-frame: on the first pix_en after rst returns high, stage 1 samples (0,0). The frame restarts cleanly, with no partial sync pulse beyond the reset edge.
- Latency: exactly one pix_en-qualified cycle from a coordinate on x/y to its colour and sync on the outputs. Colour and syncs are always mutually aligned.
- hit is sampled in the same clk in which x/y are presented. Painter logic must settle within one clk period.
- hsync low for exactly H_SYNC pix_en strobes per line. vsync low for exactly V_SYNC full lines (V_SYNC*H_TOTAL strobes).
- Frame period = H_TOTAL*V_TOTAL strobes = 420000.

## Structure
- Shared display package holds:
  - the 640x480@60 timing constants
  - the RGB333 colour type and named colours
  - the coordinate width (11)
- Painters and this block both take their widths from it.
- One natural sub-module: vga_timing_counter. It contains the x/y counters, the wrap logic and the active/sync decode.
- This block adds the output register, the colour mux and frame_start.

## Test plan
- Reset then release with pix_en tied 1:
  - x=0 and y=0 immediately after reset; hsync=vsync=1; rgb=0.
  - After 1 clk, x=1.
  - frame_start pulses on the first clk after reset release.
- Line wrap: at x=799, y=10, one strobe later x=0, y=11. At y=524, x=799, one strobe later x=0, y=0, and frame_start pulses one clk after that.
- Hsync: hsync falls on the clk after x=656 is presented, stays low for 96 strobes, and rises after x=752. Vsync is low for lines 490–491 only (1600 strobes).
- Colour: hit=1 only at (100,50) → rgb=FG_COLOR for exactly one clk, one strobe later. Hit held high at x=700 → rgb=0, video_on=0.
- pix_en toggling 1,0,1,0: x advances every second clk; outputs hold on pix_en=0; frame_start lasts one clk.
- Reset asserted at (400,300) for one clk: x=y=0 next clk; hsync=vsync=1; after release, frame_start pulses on the next strobe.

Source files
------------

// File: rtl/vga_scan_driver_pkg.sv
// Shared display definitions: 640x480@60 timing, coordinate width and RGB333 colours.
// Painters and the scan driver both size their coordinate buses from here.
package vga_scan_driver_pkg;

    localparam int COORD_W = 11;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [2:0] b;
    } rgb333_t;

    localparam rgb333_t RGB_WHITE = 9'b111_111_111;
    localparam rgb333_t RGB_BLACK = 9'b000_000_000;

endpackage

// File: rtl/vga_timing_counter.sv
// Free-running x/y raster counters with active-area, sync-window and frame-origin decode.
// Counts run through blanking; decode is combinational from the current counts.
module vga_timing_counter
    import vga_scan_driver_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   pix_en,
    output coord_t x,
    output coord_t y,
    output logic   active,
    output logic   hsync_n,
    output logic   vsync_n,
    output logic   origin
);

    localparam coord_t H_LAST = coord_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam coord_t V_LAST = coord_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam coord_t H_ACT  = coord_t'(H_ACTIVE);
    localparam coord_t V_ACT  = coord_t'(V_ACTIVE);
    localparam coord_t H_SS   = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t H_SE   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t V_SS   = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t V_SE   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

    coord_t x_q, x_d;
    coord_t y_q, y_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (pix_en) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + coord_t'(1);
            end else begin
                x_d = x_q + coord_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x       = x_q;
    assign y       = y_q;
    assign active  = (x_q < H_ACT) && (y_q < V_ACT);
    assign hsync_n = !((x_q >= H_SS) && (x_q < H_SE));
    assign vsync_n = !((y_q >= V_SS) && (y_q < V_SE));
    assign origin  = (x_q == '0) && (y_q == '0);

endmodule

// File: rtl/vga_scan_driver.sv
// VGA scan driver: presents raster coordinates to the painters and registers
// their hit result into RGB, sync, video_on and frame_start one strobe later.
module vga_scan_driver
    import vga_scan_driver_pkg::*;
#(
    parameter int      H_ACTIVE = VGA_H_ACTIVE,
    parameter int      H_FP     = VGA_H_FP,
    parameter int      H_SYNC   = VGA_H_SYNC,
    parameter int      H_BP     = VGA_H_BP,
    parameter int      V_ACTIVE = VGA_V_ACTIVE,
    parameter int      V_FP     = VGA_V_FP,
    parameter int      V_SYNC   = VGA_V_SYNC,
    parameter int      V_BP     = VGA_V_BP,
    parameter rgb333_t FG_COLOR = RGB_WHITE,
    parameter rgb333_t BG_COLOR = RGB_BLACK
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_en,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    input  logic               hit,
    output logic               hsync,
    output logic               vsync,
    output logic [2:0]         red,
    output logic [2:0]         green,
    output logic [2:0]         blue,
    output logic               video_on,
    output logic               frame_start
);

    logic active, hsync_n, vsync_n, origin;

    vga_timing_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk     (clk),
        .rst     (rst),
        .pix_en  (pix_en),
        .x       (x),
        .y       (y),
        .active  (active),
        .hsync_n (hsync_n),
        .vsync_n (vsync_n),
        .origin  (origin)
    );

    rgb333_t rgb_q, rgb_d;
    logic    hsync_q, hsync_d;
    logic    vsync_q, vsync_d;
    logic    video_on_q, video_on_d;
    logic    frame_start_q, frame_start_d;

    always_comb begin
        rgb_d         = rgb_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        video_on_d    = video_on_q;
        // Not held across idle clocks: the pulse must be exactly one clk wide.
        frame_start_d = pix_en && origin;
        if (pix_en) begin
            video_on_d = active;
            rgb_d      = active ? (hit ? FG_COLOR : BG_COLOR) : RGB_BLACK;
            hsync_d    = hsync_n;
            vsync_d    = vsync_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rgb_q         <= RGB_BLACK;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            rgb_q         <= rgb_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign red         = rgb_q.r;
    assign green       = rgb_q.g;
    assign blue        = rgb_q.b;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scan_driver.sv
// Directed bench for vga_scan_driver: full 640x480 instance for line/hsync/colour/reset
// behaviour, plus a tiny-timing instance to cover vsync and whole-frame wrap quickly.
module tb_vga_scan_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Full-size instance
    logic        rst = 1'b0;
    logic        pix_en = 1'b1;
    logic [1:0]  hit_mode = 2'd0;
    logic        hit;
    logic [10:0] x, y;
    logic        hsync, vsync, video_on, frame_start;
    logic [2:0]  red, green, blue;
    logic [8:0]  rgb;

    always_comb begin
        hit = 1'b0;
        if (hit_mode == 2'd2) hit = 1'b1;
        else if (hit_mode == 2'd1) hit = (x == 11'd100) && (y == 11'd50);
    end
    assign rgb = {red, green, blue};

    vga_scan_driver dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .x(x), .y(y), .hit(hit),
        .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
        .video_on(video_on), .frame_start(frame_start)
    );

    // Tiny instance: H_TOTAL=15, V_TOTAL=11, frame=165, vsync lines 7..8
    logic        rst1 = 1'b0;
    logic        pe1 = 1'b1;
    logic        hit1 = 1'b0;
    logic [10:0] x1, y1;
    logic        hs1, vs1, vo1, fs1;
    logic [2:0]  r1, g1, b1;

    vga_scan_driver #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) dut_small (
        .clk(clk), .rst(rst1), .pix_en(pe1), .x(x1), .y(y1), .hit(hit1),
        .hsync(hs1), .vsync(vs1), .red(r1), .green(g1), .blue(b1),
        .video_on(vo1), .frame_start(fs1)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic advance_main(input int tx, input int ty, input int limit);
        int n = 0;
        while (!(32'(x) == tx && 32'(y) == ty) && n < limit) begin
            tick();
            n++;
        end
        check($sformatf("reach_%0d_%0d", tx, ty), 32'(32'(x) == tx && 32'(y) == ty), 1);
    endtask

    task automatic advance_small(input int tx, input int ty, input int limit);
        int n = 0;
        while (!(32'(x1) == tx && 32'(y1) == ty) && n < limit) begin
            tick();
            n++;
        end
        check($sformatf("small_reach_%0d_%0d", tx, ty), 32'(32'(x1) == tx && 32'(y1) == ty), 1);
    endtask

    initial begin
        int lows, fs_cnt, vs_low, hs_low, vo_cnt;
        logic [8:0] rgb_or;

        // Reset state
        tick(); tick();
        check("rst_x", 32'(x), 0);
        check("rst_y", 32'(y), 0);
        check("rst_hsync", 32'(hsync), 1);
        check("rst_vsync", 32'(vsync), 1);
        check("rst_rgb", 32'(rgb), 0);
        check("rst_video_on", 32'(video_on), 0);
        check("rst_frame_start", 32'(frame_start), 0);

        rst = 1'b1;
        tick();
        check("rel_x", 32'(x), 1);
        check("rel_frame_start", 32'(frame_start), 1);
        check("rel_video_on", 32'(video_on), 1);
        tick();
        check("rel_x2", 32'(x), 2);
        check("rel_frame_start_drop", 32'(frame_start), 0);

        // Hsync window 656..751
        advance_main(656, 0, 1000);
        check("hs_before", 32'(hsync), 1);
        tick();
        check("hs_fall", 32'(hsync), 0);
        lows = 0;
        while (hsync == 1'b0 && lows < 200) begin
            lows++;
            tick();
        end
        check("hs_width", 32'(lows), 96);
        check("hs_rise_x", 32'(x), 753);
        check("vs_line0", 32'(vsync), 1);

        // Line wrap
        advance_main(799, 10, 10000);
        tick();
        check("wrap_x", 32'(x), 0);
        check("wrap_y", 32'(y), 11);

        // Single hit pixel at (100,50)
        hit_mode = 2'd1;
        advance_main(100, 50, 40000);
        check("hit_pre_rgb", 32'(rgb), 0);
        tick();
        check("hit_rgb", 32'(rgb), 9'h1FF);
        check("hit_video_on", 32'(video_on), 1);
        tick();
        check("hit_post_rgb", 32'(rgb), 0);

        // Hit held high: blanked outside active area, FG inside
        hit_mode = 2'd2;
        advance_main(700, 50, 1000);
        tick();
        check("blank_rgb", 32'(rgb), 0);
        check("blank_video_on", 32'(video_on), 0);
        advance_main(5, 51, 1000);
        tick();
        check("held_hit_rgb", 32'(rgb), 9'h1FF);
        hit_mode = 2'd0;

        // Reset mid-frame while hsync is low
        advance_main(700, 51, 1000);
        check("mid_hs_low", 32'(hsync), 0);
        rst = 1'b0;
        tick();
        check("mid_rst_x", 32'(x), 0);
        check("mid_rst_y", 32'(y), 0);
        check("mid_rst_hsync", 32'(hsync), 1);
        check("mid_rst_vsync", 32'(vsync), 1);
        check("mid_rst_video_on", 32'(video_on), 0);
        rst = 1'b1;

        // pix_en toggling 0,1,0,1
        pix_en = 1'b0;
        tick();
        check("tog0_x", 32'(x), 0);
        check("tog0_fs", 32'(frame_start), 0);
        check("tog0_video_on", 32'(video_on), 0);
        pix_en = 1'b1;
        tick();
        check("tog1_x", 32'(x), 1);
        check("tog1_fs", 32'(frame_start), 1);
        check("tog1_video_on", 32'(video_on), 1);
        pix_en = 1'b0;
        tick();
        check("tog2_x", 32'(x), 1);
        check("tog2_fs", 32'(frame_start), 0);
        check("tog2_video_on", 32'(video_on), 1);
        pix_en = 1'b1;
        tick();
        check("tog3_x", 32'(x), 2);
        check("tog3_fs", 32'(frame_start), 0);

        // Tiny-timing instance: whole frame, vsync, frame wrap
        rst1 = 1'b1;
        tick();
        check("small_fs_first", 32'(fs1), 1);
        fs_cnt = 0; vs_low = 0; hs_low = 0; vo_cnt = 0; rgb_or = '0;
        for (int i = 0; i < 165; i++) begin
            if (i > 0) tick();
            fs_cnt += int'(fs1);
            vs_low += int'(!vs1);
            hs_low += int'(!hs1);
            vo_cnt += int'(vo1);
            rgb_or |= {r1, g1, b1};
        end
        check("small_fs_once", 32'(fs_cnt), 1);
        check("small_vs_low", 32'(vs_low), 30);
        check("small_hs_low", 32'(hs_low), 33);
        check("small_active", 32'(vo_cnt), 48);
        check("small_rgb_bg", 32'(rgb_or), 0);
        tick();
        check("small_fs_period", 32'(fs1), 1);

        advance_small(14, 10, 400);
        tick();
        check("small_wrap_x", 32'(x1), 0);
        check("small_wrap_y", 32'(y1), 0);
        check("small_wrap_fs_early", 32'(fs1), 0);
        tick();
        check("small_wrap_fs", 32'(fs1), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
